datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Single-cycle 16-bit CR16-style execution datapath: 16x16 register file, ALU and flag register.
- Executes one instruction word per clock and presents the last write-back value on rout for display.
- Sits under the top-level sequencer (which supplies instruction words and feeds flags[3] back as cin).
- rout drives four hex 7-segment decoders (hexTo7Seg) at the top level; the decoders are outside this block.

Parameters:
- WIDTH, 16, data/register width.
- NREGS, 16, register count (4-bit register addresses).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- opCode  input  16  instruction word executed on next rising clk
- cin  input  1  carry-in used by ADDC/ADDCI
- flags  output  5  registered flags {N,C,F,L,Z} = [4]N [3]C [2]F [1]L [0]Z
- rout  output  16  registered copy of last value written to the register file

Behaviour:
- Reset (async, active-high): r0..r15 = 0, flags = 0, rout = 0. Held while reset=1. r0 is an ordinary writable register (not hardwired zero).
- Instruction fields:
  - [15:12] op
  - [11:8] Rdest
  - [7:4] ext (register form) or imm[7:4]
  - [3:0] Rsrc (register form) or imm[3:0]
- Register form (op=0000), ext selects the operation:
  - 0101 ADD: Rdest = Rdest + Rsrc
  - 0110 ADDU: unsigned add
  - 0111 ADDC: Rdest + Rsrc + cin
  - 1001 SUB: Rdest - Rsrc
  - 1011 CMP: no write
  - 0001 AND, 0010 OR, 0011 XOR
  - 1101 MOV: Rdest = Rsrc
- Immediate forms, op = same code as ext; imm8 = opCode[7:0], sign-extended to 16 bits:
  - 0101 ADDI, 0110 ADDUI, 0111 ADDCI, 1001 SUBI, 1011 CMPI
  - 0001 ANDI, 0010 ORI, 0011 XORI
  - 1101 MOVI: Rdest = sext(imm8)
- Any other encoding is a NOP: no register, flag or rout change.
- Latency: operands are read combinationally; result is written to Rdest at the rising clk after opCode is presented. Back-to-back dependent instructions work, since each result is visible to the next cycle's instruction.
- rout is loaded with the write-back data on every register write. CMP/CMPI/NOP leave rout unchanged.
- Arithmetic is 16-bit with wrap-around.
- Flag updates:
  - C = carry out of bit 15 (ADD/ADDU/ADDC/ADDI/ADDUI/ADDCI), or borrow (SUB/SUBI).
  - F = signed overflow (ADD/ADDC/SUB families); ADDU/ADDUI leave F unchanged.
  - CMP/CMPI (A = Rdest, B = Rsrc/imm): Z = (A==B), N = (A<B signed), L = (A<B unsigned). C and F are unchanged.
  - Logical ops and MOV leave all flags unchanged.
  - Flags not written by an instruction hold their value.
- Rdest == Rsrc is legal (e.g. MOV r15,r15 is a no-change write; rout = r15).
- Reset asserted mid-stream overrides any pending write in the same cycle.

Test Plan:
- Reset: assert reset, apply clocks with ADD opcodes -> all regs, flags, rout remain 0. Deassert, ADDI r0,1 (0x5001) -> rout=0x0001.
- Fibonacci chain:
  - Sequence: ADDI r0,1; ADDI r1,1; then alternating ADD (0x0150, 0x0250, 0x0351, ...) and MOV (0x02D1, 0x03D2, ...) up to ADD r15,r13 (0x0F5D).
  - Required rout per step: 1,1,2,2,3,3,5,5,8,...; final rout = 0x063D (1597).
  - MOV r15,r15 (0x0FDF) afterwards -> rout stays 0x063D.
- Carry/overflow: MOVI r1,-1 (0xD1FF); ADDI r1,1 -> rout=0x0000, flags[3]=1. Then ADDC r2,r3 with r2=r3=0, cin=1 -> rout=0x0001.
- Signed overflow: r1=0x7FFF, ADD r1,r1 -> rout=0xFFFE, F=1, C=0.
- Compare: r1=5, r2=0xFFFF, CMP r1,r2 -> Z=0, N=0, L=1; registers and rout unchanged. CMP r1,r1 -> Z=1.
- Async reset mid-run: assert reset between clock edges -> rout and flags go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/datapath.sv
// Single-cycle CR16-style execution datapath: register file, ALU and {N,C,F,L,Z} flags.
// Operands are read combinationally; the result, flags and rout update on the next rising clk.
module datapath #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      opCode,
   input  logic             cin,
   output logic [4:0]       flags,
   output logic [WIDTH-1:0] rout
);

   localparam logic [3:0] FN_AND  = 4'b0001;
   localparam logic [3:0] FN_OR   = 4'b0010;
   localparam logic [3:0] FN_XOR  = 4'b0011;
   localparam logic [3:0] FN_ADD  = 4'b0101;
   localparam logic [3:0] FN_ADDU = 4'b0110;
   localparam logic [3:0] FN_ADDC = 4'b0111;
   localparam logic [3:0] FN_SUB  = 4'b1001;
   localparam logic [3:0] FN_CMP  = 4'b1011;
   localparam logic [3:0] FN_MOV  = 4'b1101;

   localparam int FN = 4, FC = 3, FF = 2, FL = 1, FZ = 0;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [4:0]       flags_q, flags_d;
   logic [WIDTH-1:0] rout_q;

   logic [3:0]       op, rd, rs, fn;
   logic             is_reg;
   logic [WIDTH-1:0] a, b, imm, res;
   logic [WIDTH:0]   add_w, sub_w;
   logic             add_ovf, sub_ovf, wr_en;

   assign op     = opCode[15:12];
   assign rd     = opCode[11:8];
   assign rs     = opCode[3:0];
   assign is_reg = (op == 4'b0000);
   // Immediate forms reuse the register-form function codes in the op field.
   assign fn     = is_reg ? opCode[7:4] : op;
   assign imm    = {{(WIDTH-8){opCode[7]}}, opCode[7:0]};
   assign a      = regs_q[rd];
   assign b      = is_reg ? regs_q[rs] : imm;

   assign add_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (fn == FN_ADDC) & cin};
   assign sub_w   = {1'b0, a} - {1'b0, b};
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      res     = '0;
      wr_en   = 1'b0;
      flags_d = flags_q;
      case (fn)
         FN_ADD, FN_ADDC: begin
            res         = add_w[WIDTH-1:0];
            wr_en       = 1'b1;
            flags_d[FC] = add_w[WIDTH];
            flags_d[FF] = add_ovf;
         end
         FN_ADDU: begin
            res         = add_w[WIDTH-1:0];
            wr_en       = 1'b1;
            flags_d[FC] = add_w[WIDTH];
         end
         FN_SUB: begin
            res         = sub_w[WIDTH-1:0];
            wr_en       = 1'b1;
            flags_d[FC] = sub_w[WIDTH];
            flags_d[FF] = sub_ovf;
         end
         FN_CMP: begin
            flags_d[FZ] = (a == b);
            flags_d[FN] = ($signed(a) < $signed(b));
            flags_d[FL] = (a < b);
         end
         FN_AND: begin res = a & b; wr_en = 1'b1; end
         FN_OR:  begin res = a | b; wr_en = 1'b1; end
         FN_XOR: begin res = a ^ b; wr_en = 1'b1; end
         FN_MOV: begin res = b;     wr_en = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         flags_q <= '0;
         rout_q  <= '0;
      end else begin
         flags_q <= flags_d;
         if (wr_en) begin
            regs_q[rd] <= res;
            rout_q     <= res;
         end
      end
   end

   assign flags = flags_q;
   assign rout  = rout_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus random instructions
// compared against an integer-arithmetic reference model.
module tb_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] opCode = 16'h0000;
   logic        cin = 1'b0;
   logic [4:0]  flags;
   logic [15:0] rout;

   int errors = 0;
   int checks = 0;

   int         mregs [16];
   int         mrout;
   logic [4:0] mfl;   // {N,C,F,L,Z}

   datapath #(.WIDTH(16), .NREGS(16)) dut (
      .clk(clk), .reset(reset), .opCode(opCode), .cin(cin), .flags(flags), .rout(rout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   function automatic bit out_of_range(input int v);
      return (v > 32767) || (v < -32768);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = 0;
      mrout = 0;
      mfl   = '0;
   endtask

   // Reference semantics from the instruction set description, using plain integers.
   task automatic model_exec(input logic [15:0] w, input logic c);
      int op, rd, rs, ext, fn, a, b, r;
      bit wr;
      op  = int'(w[15:12]);
      rd  = int'(w[11:8]);
      ext = int'(w[7:4]);
      rs  = int'(w[3:0]);
      fn  = (op == 0) ? ext : op;
      a   = mregs[rd];
      if (op == 0) b = mregs[rs];
      else         b = (int'(w[7:0]) >= 128) ? int'(w[7:0]) + 65280 : int'(w[7:0]);
      wr = 1'b1;
      r  = 0;
      case (fn)
         5:  begin r = a + b;            mfl[3] = (r > 65535); mfl[2] = out_of_range(sgn(a) + sgn(b)); end
         6:  begin r = a + b;            mfl[3] = (r > 65535); end
         7:  begin r = a + b + int'(c);  mfl[3] = (r > 65535); mfl[2] = out_of_range(sgn(a) + sgn(b) + int'(c)); end
         9:  begin r = a - b;            mfl[3] = (a < b);     mfl[2] = out_of_range(sgn(a) - sgn(b)); end
         11: begin wr = 1'b0; mfl[0] = (a == b); mfl[4] = (sgn(a) < sgn(b)); mfl[1] = (a < b); end
         1:  r = a & b;
         2:  r = a | b;
         3:  r = a ^ b;
         13: r = b;
         default: wr = 1'b0;
      endcase
      if (wr) begin
         r = r & 32'hFFFF;
         mregs[rd] = r;
         mrout     = r;
      end
   endtask

   task automatic step(input logic [15:0] w, input logic c, input string tag);
      opCode = w;
      cin    = c;
      model_exec(w, c);
      @(posedge clk);
      #1;
      chk({tag, " rout"}, 32'(rout), 32'(mrout));
      chk({tag, " flags"}, 32'(flags), 32'(mfl));
   endtask

   logic [3:0] fns [9] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hD};

   initial begin
      logic [15:0] w;
      model_reset();

      // Reset held across edges with ADD opcodes present.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         opCode = 16'h0150 + 16'(i);
         @(posedge clk); #1;
      end
      chk("reset rout", 32'(rout), 32'h0);
      chk("reset flags", 32'(flags), 32'h0);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      step(16'h0FDF, 1'b0, "regs cleared r15");
      step(16'h5001, 1'b0, "ADDI r0,1");
      chk("ADDI r0,1 const", 32'(rout), 32'h0001);

      // Fibonacci chain.
      step(16'h5101, 1'b0, "fib ADDI r1");
      step(16'h0150, 1'b0, "fib ADD r1,r0");
      for (int k = 2; k < 16; k++) begin
         step({4'h0, 4'(k), 4'hD, 4'(k - 1)}, 1'b0, "fib MOV");
         step({4'h0, 4'(k), 4'h5, 4'(k - 2)}, 1'b0, "fib ADD");
      end
      chk("fib final", 32'(rout), 32'h063D);
      step(16'h0FDF, 1'b0, "MOV r15,r15");
      chk("MOV r15,r15 const", 32'(rout), 32'h063D);

      // Carry out and ADDC carry-in.
      step(16'hD1FF, 1'b0, "MOVI r1,-1");
      step(16'h5101, 1'b0, "ADDI carry");
      chk("ADDI carry C", 32'(flags[3]), 32'h1);
      chk("ADDI carry rout", 32'(rout), 32'h0);
      step(16'hD200, 1'b0, "MOVI r2,0");
      step(16'hD300, 1'b0, "MOVI r3,0");
      step(16'h0273, 1'b1, "ADDC r2,r3");
      chk("ADDC const", 32'(rout), 32'h0001);

      // Signed overflow: build 0x7FFF then double it.
      step(16'hD101, 1'b0, "MOVI r1,1");
      for (int i = 0; i < 15; i++) step(16'h0151, 1'b0, "shift r1");
      step(16'h9101, 1'b0, "SUBI r1,1");
      chk("r1 0x7FFF", 32'(rout), 32'h7FFF);
      step(16'h0151, 1'b0, "ADD ovf");
      chk("ovf rout", 32'(rout), 32'hFFFE);
      chk("ovf F", 32'(flags[2]), 32'h1);
      chk("ovf C", 32'(flags[3]), 32'h0);

      // Compare.
      step(16'hD105, 1'b0, "MOVI r1,5");
      step(16'hD2FF, 1'b0, "MOVI r2,-1");
      step(16'h01B2, 1'b0, "CMP r1,r2");
      chk("CMP ZNL", 32'({flags[0], flags[4], flags[1]}), 32'b001);
      chk("CMP rout held", 32'(rout), 32'h FFFF);
      step(16'h01B1, 1'b0, "CMP r1,r1");
      chk("CMP eq Z", 32'(flags[0]), 32'h1);
      step(16'hF123, 1'b0, "NOP F123");
      step(16'h0140, 1'b0, "NOP ext4");

      // Random instruction stream.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) w = 16'($urandom);
         else begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w[15:12] = fns[$urandom_range(0, 8)];
            else begin w[15:12] = 4'h0; w[7:4] = fns[$urandom_range(0, 8)]; end
         end
         step(w, 1'($urandom_range(0, 1)), "random");
      end

      // Asynchronous reset between clock edges.
      step(16'hD3FF, 1'b0, "pre-reset MOVI");
      step(16'h5301, 1'b0, "pre-reset carry");
      #2 reset = 1'b1;
      #1;
      chk("async reset rout", 32'(rout), 32'h0);
      chk("async reset flags", 32'(flags), 32'h0);
      opCode = 16'h5701;
      @(posedge clk); #1;
      chk("reset overrides write", 32'(rout), 32'h0);
      #2 reset = 1'b0;
      model_reset();
      step(16'h0373, 1'b0, "post-reset r3");
      step(16'h5001, 1'b0, "post-reset ADDI");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
